// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Blocking instruction fetch unit with a single request in
//               flight, a one-entry decode buffer and branch-unit redirects.
//               Optional macro IFU_MISALIGN_CHECK_EN adds inst_misalign and
//               turns misaligned redirect targets into a flagged nop.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic            inst_misalign
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [XLEN-1:0] c_nop     = 32'h0000_0013;
    localparam logic [XLEN-1:0] c_pc_step = 32'd4;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [XLEN-1:0] r_inst_q;
    logic [XLEN-1:0] r_inst_pc_q;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_drop_nxt;
    logic            w_load_rsp;
    logic            w_load_nop;
    logic            w_req_fire;
    logic            w_inst_fire;

    // Misalignment qualifiers collapse to constant zero when the check is off.
    logic            w_tgt_mis;
    logic            w_pc_mis;
    logic            w_halted;
    logic            w_out_mis;

`ifdef IFU_MISALIGN_CHECK_EN
    logic            r_misalign;
    logic            r_halt;

    assign w_tgt_mis     = |redirect_target[1:0];
    assign w_pc_mis      = |r_pc[1:0];
    assign w_halted      = r_halt;
    assign w_out_mis     = r_misalign;
    assign inst_misalign = r_misalign;
`else
    assign w_tgt_mis     = 1'b0;
    assign w_pc_mis      = 1'b0;
    assign w_halted      = 1'b0;
    assign w_out_mis     = 1'b0;
`endif

    assign req_valid   = (r_state == S_REQ) & ~redirect_valid & rst_n & ~w_pc_mis;
    assign req_addr    = r_pc;
    assign inst_valid  = (r_state == S_OUT) & ~redirect_valid & rst_n;
    assign inst        = r_inst_q;
    assign inst_pc     = r_inst_pc_q;
    assign w_req_fire  = req_valid & req_ready;
    assign w_inst_fire = inst_valid & inst_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_load_rsp  = 1'b0;
        w_load_nop  = 1'b0;
        if (redirect_valid) begin
            w_pc_nxt = redirect_target;
            case (r_state)
                S_WAIT: begin
                    // The outstanding response must still be absorbed.
                    if (rsp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: begin
                    if (w_tgt_mis) begin
                        w_state_nxt = S_OUT;
                        w_load_nop  = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_pc_mis) begin
                        if (!w_halted) begin
                            w_state_nxt = S_OUT;
                            w_load_nop  = 1'b1;
                        end
                    end else if (w_req_fire) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = S_REQ;
                        end else begin
                            w_load_rsp  = 1'b1;
                            w_state_nxt = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (w_inst_fire) begin
                        w_state_nxt = S_REQ;
                        if (!w_out_mis) begin
                            w_pc_nxt = r_pc + c_pc_step;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst_q    <= '0;
            r_inst_pc_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_load_rsp) begin
                r_inst_q    <= rsp_data;
                r_inst_pc_q <= r_pc;
            end else if (w_load_nop) begin
                r_inst_q    <= c_nop;
                r_inst_pc_q <= w_pc_nxt;
            end
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Once a misaligned nop is consumed the unit parks until redirected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            if (w_load_rsp) begin
                r_misalign <= 1'b0;
            end else if (w_load_nop) begin
                r_misalign <= 1'b1;
            end
            if (redirect_valid) begin
                r_halt <= 1'b0;
            end else if (w_inst_fire && r_misalign) begin
                r_halt <= 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && rsp_valid) begin
            assert (r_state == S_WAIT)
            else $error("ifu_fetch: response arrived outside S_WAIT");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Directed scoreboard bench for ifu_fetch with a latency-
//               programmable instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data  = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc_cnt  = 0;
    int          mem_lat  = 1;
    bit          force_en = 1'b0;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] exp_req[$];
    logic [63:0] exp_inst[$];
    int          hs_q[$];
    logic [63:0] mon_e;

    ifu_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h8000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_req.push_back(a);
        exp_inst.push_back({a, mdata(a)});
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_req.size() == 0) req_ready = 1'b0;
            if (exp_req.size() == 0 && exp_inst.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_inst_valid(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_req.size() == 0) req_ready = 1'b0;
            #1;
            if (inst_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_accept(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_req.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        req_ready = 1'b0;
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    // Memory responder: latency counted from the accepting edge.
    always @(posedge clk) begin
        rsp_valid <= 1'b0;
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= pend_data;
                    pend      <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
            if (req_valid && req_ready) begin
                if (mem_lat <= 1) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= force_en ? 32'hDEAD_BEEF : mdata(req_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_cnt  <= mem_lat - 2;
                    pend_data <= force_en ? 32'hDEAD_BEEF : mdata(req_addr);
                end
            end
        end
    end

    // Scoreboard monitor, sampled mid-cycle after stimulus settles.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (req_valid && req_ready) begin
                if (exp_req.size() == 0) chk("req_unexpected", 32'(exp_req.size()), 32'd1);
                else chk("req_addr", req_addr, exp_req.pop_front());
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) begin
                    chk("inst_unexpected", inst, 32'h0000_0000 ^ ~inst);
                end else begin
                    mon_e = exp_inst.pop_front();
                    chk("inst_pc", inst_pc, mon_e[63:32]);
                    chk("inst_word", inst, mon_e[31:0]);
                end
                hs_q.push_back(cyc_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        req_ready = 1'b0; inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req_addr", req_addr, 32'h8000_0000);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Sequential fetch from reset.
        @(negedge clk);
        push_fetch(32'h8000_0000); push_fetch(32'h8000_0004); push_fetch(32'h8000_0008);
        req_ready = 1'b1; rst_n = 1'b1;
        #1;
        chk("first_req_valid", {31'd0, req_valid}, 32'd1);
        chk("first_req_addr", req_addr, 32'h8000_0000);
        run_until_idle("seq_idle", 40);
        chk("hs_count", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() >= 3) begin
            chk("rate_1", 32'(hs_q[1] - hs_q[0]), 32'd3);
            chk("rate_2", 32'(hs_q[2] - hs_q[1]), 32'd3);
        end
        hs_q.delete();

        // Decode back-pressure.
        inst_ready = 1'b0; push_fetch(32'h8000_000C); req_ready = 1'b1;
        wait_inst_valid("stall_wait", 20);
        for (int i = 0; i < 5; i++) begin
            chk("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst", inst, 32'h0000_001F);
            chk("stall_inst_pc", inst_pc, 32'h8000_000C);
            chk("stall_req_valid", {31'd0, req_valid}, 32'd0);
            chk("stall_pc", req_addr, 32'h8000_000C);
            @(negedge clk); #1;
        end
        @(negedge clk);
        inst_ready = 1'b1;
        run_until_idle("stall_idle", 20);

        // Redirect during S_WAIT; late response must be dropped.
        exp_req.push_back(32'h8000_0010); mem_lat = 3; force_en = 1'b1; req_ready = 1'b1;
        wait_accept("wait_acc", 10);
        force_en = 1'b0; mem_lat = 1;
        redirect_valid = 1'b1; redirect_target = 32'h8000_0100;
        #1;
        chk("wredir_req_valid", {31'd0, req_valid}, 32'd0);
        chk("wredir_inst_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0; push_fetch(32'h8000_0100); req_ready = 1'b1;
        #1;
        chk("wredir_hold_req", {31'd0, req_valid}, 32'd0);
        chk("wredir_pc", req_addr, 32'h8000_0100);
        run_until_idle("wredir_idle", 30);

        // Redirect coincident with the response.
        exp_req.push_back(32'h8000_0104); mem_lat = 2; req_ready = 1'b1;
        wait_accept("coin_acc", 10);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_target = 32'h8000_0200;
        #1;
        chk("coin_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("coin_req_valid", {31'd0, req_valid}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("coin_next_req", {31'd0, req_valid}, 32'd1);
        chk("coin_next_addr", req_addr, 32'h8000_0200);
        chk("coin_no_inst", {31'd0, inst_valid}, 32'd0);
        push_fetch(32'h8000_0200); mem_lat = 1; req_ready = 1'b1;
        run_until_idle("coin_idle", 20);

        // Redirect kills a presented instruction; then PC wrap.
        exp_req.push_back(32'h8000_0204); req_ready = 1'b1; inst_ready = 1'b1;
        wait_inst_valid("kill_wait", 20);
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        #1;
        chk("kill_inst_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("kill_req_valid", {31'd0, req_valid}, 32'd1);
        chk("kill_req_addr", req_addr, 32'hFFFF_FFFC);
        push_fetch(32'hFFFF_FFFC); req_ready = 1'b1;
        run_until_idle("wrap_idle", 20);
        #1;
        chk("wrap_addr", req_addr, 32'h0000_0000);
        chk("wrap_req_valid", {31'd0, req_valid}, 32'd1);
        push_fetch(32'h0000_0000); req_ready = 1'b1;
        run_until_idle("zero_idle", 20);

        // Back-to-back redirects in S_REQ: last target wins.
        req_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0300;
        #1;
        chk("b2b_req_gate1", {31'd0, req_valid}, 32'd0);
        @(negedge clk);
        redirect_target = 32'h8000_0400;
        #1;
        chk("b2b_req_gate2", {31'd0, req_valid}, 32'd0);
        chk("b2b_first_pc", req_addr, 32'h8000_0300);
        @(negedge clk);
        redirect_valid = 1'b0; push_fetch(32'h8000_0400);
        #1;
        chk("b2b_last_pc", req_addr, 32'h8000_0400);
        run_until_idle("b2b_idle", 20);

        // Reset while an instruction is held.
        inst_ready = 1'b0; exp_req.push_back(32'h8000_0404); req_ready = 1'b1;
        wait_inst_valid("rst_mid_wait", 20);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_gate", {31'd0, inst_valid}, 32'd0);
        @(negedge clk); #1;
        chk("rst_mid_inst_pc", inst_pc, 32'h0);
        chk("rst_mid_inst", inst, 32'h0);
        chk("rst_mid_pc", req_addr, 32'h8000_0000);
        @(negedge clk);
        inst_ready = 1'b1; push_fetch(32'h8000_0000); req_ready = 1'b1; rst_n = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, req_valid}, 32'd1);
        run_until_idle("rst_mid_idle", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
